// File: rtl/commit_trace_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | commit_trace_pkg : shared types for the commit trace buffer      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package commit_trace_pkg;

  localparam int unsigned c_pc_w        = 64;
  localparam logic [31:0] c_ebreak_inst = 32'h00100073;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } trace_state_t;

  typedef struct packed {
    logic              is_ebreak;
    logic [c_pc_w-1:0] pc;
  } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/commit_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | commit_fifo : synchronous FIFO of trace entries                  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module commit_fifo
  import commit_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  trace_entry_t           push_data,
  input  logic                   pop,
  output trace_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned         c_ptr_w   = $clog2(DEPTH);
  localparam logic [c_ptr_w-1:0]  c_ptr_one = 1;
  localparam logic [c_ptr_w:0]    c_cnt_one = 1;

  trace_entry_t       r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;

  // Storage is not reset; only slots below r_count are ever observed.
  always_ff @(posedge clock) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/commit_trace_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | commit_trace_buf : retire-event FIFO with ebreak halt, counters  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module commit_trace_buf
  import commit_trace_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HANG_CYCLES = 1000000,
  parameter logic [31:0] EBREAK_INST = c_ebreak_inst
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_pc,
  input  logic [31:0]       wb_inst,
  input  logic              out_ready,
  output logic [DATA_W-1:0] pc,
  output logic              inst_commit,
  output logic              cpu_ebreak_sign,
  output logic [63:0]       instret,
  output logic              overflow,
  output logic              hang
);

  localparam int unsigned        c_cnt_w    = $clog2(DEPTH) + 1;
  localparam int unsigned        c_wd_w     = $clog2(HANG_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
  localparam logic [c_wd_w-1:0]  c_wd_limit = c_wd_w'(HANG_CYCLES);
  localparam logic [c_wd_w-1:0]  c_wd_one   = 1;

  trace_state_t       r_state;
  trace_state_t       w_state_nxt;
  trace_entry_t       w_push_entry;
  trace_entry_t       w_head;
  logic [c_cnt_w-1:0] w_count;
  logic               w_pop;
  logic               w_push_req;
  logic               w_push;
  logic               w_drop;

  logic [DATA_W-1:0]  r_pc;
  logic               r_inst_commit;
  logic               r_ebreak;
  logic [63:0]        r_instret;
  logic               r_overflow;
  logic               r_hang;
  logic [c_wd_w-1:0]  r_wd_cnt;

  assign w_push_entry.is_ebreak = (wb_inst == EBREAK_INST);
  assign w_push_entry.pc        = c_pc_w'(wb_pc);

  // A full FIFO still accepts when the head leaves on the same edge.
  assign w_pop      = (w_count != '0) && out_ready && (r_state != ST_HALT);
  assign w_push_req = (r_state == ST_RUN) && wb_valid;
  assign w_push     = w_push_req && ((w_count != c_depth) || w_pop);
  assign w_drop     = w_push_req && !w_push;

  commit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_push && w_push_entry.is_ebreak) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_pop && w_head.is_ebreak) w_state_nxt = ST_HALT;
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc          <= '0;
      r_inst_commit <= 1'b0;
      r_ebreak      <= 1'b0;
      r_instret     <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_inst_commit <= w_pop;
      r_ebreak      <= w_pop && w_head.is_ebreak;
      if (w_pop) begin
        r_pc      <= w_head.pc[DATA_W-1:0];
        r_instret <= r_instret + 64'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Watchdog only runs in RUN; it saturates at the limit and hang stays sticky.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wd_cnt <= '0;
      r_hang   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (w_push) begin
        r_wd_cnt <= '0;
      end else if (r_wd_cnt != c_wd_limit) begin
        r_wd_cnt <= r_wd_cnt + c_wd_one;
        if ((r_wd_cnt + c_wd_one) == c_wd_limit) begin
          r_hang <= 1'b1;
        end
      end
    end
  end

  assign pc              = r_pc;
  assign inst_commit     = r_inst_commit;
  assign cpu_ebreak_sign = r_ebreak;
  assign instret         = r_instret;
  assign overflow        = r_overflow;
  assign hang            = r_hang;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buf.sv
`default_nettype none
// Self-checking bench for commit_trace_buf: table vectors plus a commit scoreboard.
module tb_commit_trace_buf;

  localparam int          DEPTH = 8;
  localparam int          HANG  = 50;
  localparam logic [31:0] EB    = 32'h00100073;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wb_valid = 1'b0;
  logic [63:0] wb_pc = '0;
  logic [31:0] wb_inst = '0;
  logic        out_ready = 1'b1;
  logic [63:0] pc;
  logic        inst_commit;
  logic        cpu_ebreak_sign;
  logic [63:0] instret;
  logic        overflow;
  logic        hang;

  always #5 clock = ~clock;

  commit_trace_buf #(
    .DATA_W      (64),
    .DEPTH       (DEPTH),
    .HANG_CYCLES (HANG),
    .EBREAK_INST (EB)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .wb_valid        (wb_valid),
    .wb_pc           (wb_pc),
    .wb_inst         (wb_inst),
    .out_ready       (out_ready),
    .pc              (pc),
    .inst_commit     (inst_commit),
    .cpu_ebreak_sign (cpu_ebreak_sign),
    .instret         (instret),
    .overflow        (overflow),
    .hang            (hang)
  );

  typedef struct packed {
    logic [63:0] epc;
    logic        eeb;
  } exp_t;

  typedef struct packed {
    logic [63:0] vpc;
    logic [31:0] vinst;
    logic        emit;
    logic        is_eb;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_commits = 0;
  int   n_ebreak = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  int   cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every emitted commit must match the oldest expected entry.
  always @(negedge clock) begin
    if (reset && cpu_ebreak_sign && !inst_commit) begin
      chk("ebreak_without_commit", {63'd0, inst_commit}, 64'd1);
    end
    if (reset && inst_commit) begin
      exp_t e;
      n_commits++;
      if (cpu_ebreak_sign) n_ebreak++;
      if (n_commits == 1) first_cyc = cyc;
      last_cyc = cyc;
      if (sb_q.size() == 0) begin
        chk("unexpected_commit_pc", pc, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("commit_pc", pc, e.epc);
        chk("commit_ebreak", {63'd0, cpu_ebreak_sign}, {63'd0, e.eeb});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wb_valid = 1'b0;
    out_ready = 1'b1;
    sb_q.delete();
    repeat (2) tick();
    n_commits = 0;
    n_ebreak = 0;
    reset = 1'b1;
  endtask

  task automatic drive(input logic [63:0] p, input logic [31:0] ins, input bit emit, input bit is_eb);
    wb_valid = 1'b1;
    wb_pc = p;
    wb_inst = ins;
    if (emit) sb_q.push_back('{epc: p, eeb: is_eb});
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    chk(name, 64'(sb_q.size()), 64'd0);
  endtask

  vec_t ebv[4];

  initial begin
    ebv[0] = '{vpc: 64'h8000_0000, vinst: NOP, emit: 1'b1, is_eb: 1'b0};
    ebv[1] = '{vpc: 64'h8000_0004, vinst: NOP, emit: 1'b1, is_eb: 1'b0};
    ebv[2] = '{vpc: 64'h8000_0010, vinst: EB,  emit: 1'b1, is_eb: 1'b1};
    ebv[3] = '{vpc: 64'h8000_0014, vinst: NOP, emit: 1'b0, is_eb: 1'b0};

    // Reset state
    repeat (2) tick();
    chk("rst_pc", pc, 64'd0);
    chk("rst_commit", {63'd0, inst_commit}, 64'd0);
    chk("rst_ebreak", {63'd0, cpu_ebreak_sign}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_hang", {63'd0, hang}, 64'd0);

    // Single commit, two-cycle latency
    do_reset();
    drive(64'h8000_0000, NOP, 1'b1, 1'b0);
    chk("single_lat1_commit", {63'd0, inst_commit}, 64'd0);
    tick();
    chk("single_lat2_commit", {63'd0, inst_commit}, 64'd1);
    chk("single_pc", pc, 64'h8000_0000);
    tick();
    chk("single_pulse_end", {63'd0, inst_commit}, 64'd0);
    chk("single_instret", instret, 64'd1);

    // 20 back-to-back commits
    do_reset();
    for (int i = 0; i < 20; i++) drive(64'h8000_1000 + 64'(4 * i), NOP, 1'b1, 1'b0);
    wait_drain("b2b_drain");
    chk("b2b_instret", instret, 64'd20);
    chk("b2b_overflow", {63'd0, overflow}, 64'd0);
    chk("b2b_ncommits", 64'(n_commits), 64'd20);
    chk("b2b_consecutive", 64'(last_cyc - first_cyc), 64'd19);

    // Backpressure: 10 commits into an 8-deep FIFO
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) drive(64'h8000_2000 + 64'(8 * i), NOP, i < DEPTH, 1'b0);
    tick();
    chk("ovf_flag", {63'd0, overflow}, 64'd1);
    chk("ovf_no_emit_stalled", 64'(n_commits), 64'd0);
    out_ready = 1'b1;
    wait_drain("ovf_drain");
    repeat (5) tick();
    chk("ovf_instret", instret, 64'd8);
    chk("ovf_ncommits", 64'(n_commits), 64'd8);

    // Ebreak sequence: A, B, ebreak, C
    do_reset();
    for (int i = 0; i < 4; i++) drive(ebv[i].vpc, ebv[i].vinst, ebv[i].emit, ebv[i].is_eb);
    wait_drain("eb_drain");
    tick();
    chk("eb_pulse_end", {63'd0, cpu_ebreak_sign}, 64'd0);
    drive(64'h8000_0018, NOP, 1'b0, 1'b0);
    repeat (6) tick();
    chk("eb_count", 64'(n_ebreak), 64'd1);
    chk("eb_ncommits", 64'(n_commits), 64'd3);
    chk("eb_instret", instret, 64'd3);
    chk("eb_overflow", {63'd0, overflow}, 64'd0);

    // Watchdog
    do_reset();
    repeat (40) tick();
    chk("hang_early", {63'd0, hang}, 64'd0);
    repeat (15) tick();
    chk("hang_set", {63'd0, hang}, 64'd1);
    drive(64'h8000_3000, NOP, 1'b1, 1'b0);
    drive(64'h8000_3004, NOP, 1'b1, 1'b0);
    wait_drain("hang_drain");
    chk("hang_sticky", {63'd0, hang}, 64'd1);
    chk("hang_instret", instret, 64'd2);

    // Reset in the middle of DRAIN
    do_reset();
    drive(64'h8000_4000, NOP, 1'b1, 1'b0);
    wait_drain("rd_first_drain");
    out_ready = 1'b0;
    drive(64'h8000_4004, NOP, 1'b0, 1'b0);
    drive(64'h8000_4008, NOP, 1'b0, 1'b0);
    drive(64'h8000_400C, EB,  1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(64'h8000_5000 + 64'(4 * i), NOP, 1'b0, 1'b0);
    tick();
    chk("drain_ignores_wb", {63'd0, overflow}, 64'd0);
    chk("drain_pc_held", pc, 64'h8000_4000);
    chk("drain_instret", instret, 64'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_pc", pc, 64'd0);
    chk("async_rst_instret", instret, 64'd0);
    chk("async_rst_commit", {63'd0, inst_commit}, 64'd0);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    n_commits = 0;
    n_ebreak = 0;
    repeat (20) tick();
    chk("post_rst_ncommits", 64'(n_commits), 64'd0);
    chk("post_rst_ebreak", 64'(n_ebreak), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
